// File: rtl/seq_mult_unit.sv
// seq_mult_unit: shift-add multiplier with HI/LO registers and start/busy/done handshake; signed mode under MULT_SIGNED_EN
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, res;
    logic               neg_q, neg_d, neg_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
`ifdef MULT_SIGNED_EN
    assign a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (sgn && B[WIDTH-1]) ? -B : B;
    assign neg_in = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
    assign res    = neg_q ? -prod_q : prod_q;
`else
    logic unused_ok;
    assign a_mag     = A;
    assign b_mag     = B;
    assign neg_in    = 1'b0;
    assign res       = prod_q;
    assign unused_ok = sgn ^ neg_q;
`endif
    assign busy = state_q == BUSY;
    assign done = state_q == DONE;
    assign HI   = hi_q;
    assign LO   = lo_q;
    // Next state: capture on accepted start, one multiplier bit per BUSY cycle, load HI/LO on the final cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (start && state_q != BUSY) begin
            state_d = BUSY;
            cnt_d   = '0;
            mcand_d = a_mag;
            prod_d  = {{WIDTH{1'b0}}, b_mag};
            neg_d   = neg_in;
        end else if (state_q == BUSY) begin
            if (cnt_q == CW'(WIDTH)) begin
                state_d      = DONE;
                {hi_d, lo_d} = res;
            end else begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
            end
        end else begin
            state_d = IDLE;
            hi_d    = hi_we ? wdata : hi_q;
            lo_d    = lo_we ? wdata : lo_q;
        end
    end
    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: directed self-checking bench for seq_mult_unit (expectations follow MULT_SIGNED_EN)
module tb_seq_mult_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, sgn = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          errs = 0, checks = 0;
    int          lat, nb, nd;
    bit          hold_bad;
`ifdef MULT_SIGNED_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif
    typedef struct {logic [31:0] a, b; logic s; logic [31:0] eh, el;} vec_t;

    seq_mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A(a), .B(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic mul(input logic [31:0] ia, input logic [31:0] ib, input logic is, input bit disturb);
        logic [31:0] h0, l0;
        @(negedge clk);
        a = ia; b = ib; sgn = is; start = 1'b1;
        h0 = hi; l0 = lo;
        lat = -1; nb = 0; nd = 0; hold_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0;
            if (busy) begin
                nb++;
                if (hi !== h0 || lo !== l0) hold_bad = 1;
            end
            if (done) begin
                nd++;
                if (lat < 0) lat = k - 1;
            end
            if (k == 2) begin a = ~a; b = b + 32'd7; sgn = ~sgn; end
            if (disturb && k == 5) begin start = 1'b1; a = 32'h1234; b = 32'h10; end
            if (disturb && k == 10) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
        end
    endtask

    task automatic test_reset;
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A; a = 32'd9; b = 32'd9;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== 32'h0) begin errs++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin errs++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_basic;
        mul(32'd3, 32'd5, 1'b0, 1'b0);
        checks++; if (lat !== 33) begin errs++; $display("FAIL basic_latency got=%0d exp=33", lat); end
        checks++; if (nb !== 33) begin errs++; $display("FAIL basic_busy_cycles got=%0d exp=33", nb); end
        checks++; if (nd !== 1) begin errs++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
        checks++; if (hold_bad !== 1'b0) begin errs++; $display("FAIL basic_hilo_hold got=%b exp=0", hold_bad); end
        checks++; if (hi !== 32'h0) begin errs++; $display("FAIL basic_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'hF) begin errs++; $display("FAIL basic_lo got=%h exp=f", lo); end
    endtask

    task automatic test_vectors;
        vec_t v[8];
        v[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        v[1] = '{32'hFFFFFFFF, 32'h1, 1'b1, SE ? 32'hFFFFFFFF : 32'h0, 32'hFFFFFFFF};
        v[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0};
        v[3] = '{32'hFFFFFFFE, 32'h3, 1'b1, SE ? 32'hFFFFFFFF : 32'h2, 32'hFFFFFFFA};
        v[4] = '{32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, SE ? 32'h0 : 32'hFFFFFFF8, 32'hF};
        v[5] = '{32'h00010000, 32'h00010000, 1'b0, 32'h1, 32'h0};
        v[6] = '{32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'hFFFFFFFF};
        v[7] = '{32'h80000000, 32'h3, 1'b1, SE ? 32'hFFFFFFFE : 32'h1, 32'h80000000};
        for (int i = 0; i < 8; i++) begin
            mul(v[i].a, v[i].b, v[i].s, 1'b0);
            checks++; if (hi !== v[i].eh) begin errs++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi, v[i].eh); end
            checks++; if (lo !== v[i].el) begin errs++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo, v[i].el); end
            checks++; if (lat !== 33) begin errs++; $display("FAIL vec%0d_latency got=%0d exp=33", i, lat); end
        end
    endtask

    task automatic test_overlap;
        mul(32'd7, 32'd6, 1'b0, 1'b1);
        checks++; if (nd !== 1) begin errs++; $display("FAIL overlap_done_count got=%0d exp=1", nd); end
        checks++; if (lat !== 33) begin errs++; $display("FAIL overlap_latency got=%0d exp=33", lat); end
        checks++; if (hi !== 32'h0) begin errs++; $display("FAIL overlap_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h2A) begin errs++; $display("FAIL overlap_lo got=%h exp=2a", lo); end
        checks++; if (hold_bad !== 1'b0) begin errs++; $display("FAIL overlap_hilo_hold got=%b exp=0", hold_bad); end
    endtask

    task automatic test_back_to_back;
        int j;
        @(negedge clk);
        a = 32'd3; b = 32'd5; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (j = 1; j < 40 && !done; j++) @(negedge clk);
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_no_gap_busy got=%b exp=1", busy); end
        checks++; if (lo !== 32'hF) begin errs++; $display("FAIL b2b_first_lo got=%h exp=f", lo); end
        for (j = 1; j < 40 && !done; j++) @(negedge clk);
        checks++; if (j - 1 !== 33) begin errs++; $display("FAIL b2b_latency got=%0d exp=33", j - 1); end
        checks++; if (lo !== 32'h2A) begin errs++; $display("FAIL b2b_second_lo got=%h exp=2a", lo); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        mul(32'h00010000, 32'h00010000, 1'b0, 1'b0);
        @(negedge clk);
        a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h0) begin errs++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin errs++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        checks++; if (ndone !== 0) begin errs++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_writes;
        int j;
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        checks++; if (lo !== 32'h1234) begin errs++; $display("FAIL mtlo_lo got=%h exp=1234", lo); end
        checks++; if (hi !== 32'h0) begin errs++; $display("FAIL mtlo_hi got=%h exp=0", hi); end
        hi_we = 1'b1; wdata = 32'h5555;
        @(negedge clk);
        hi_we = 1'b0;
        checks++; if (hi !== 32'h5555) begin errs++; $display("FAIL mthi_hi got=%h exp=5555", hi); end
        checks++; if (lo !== 32'h1234) begin errs++; $display("FAIL mthi_lo got=%h exp=1234", lo); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77;
        @(negedge clk);
        checks++; if (hi !== 32'h77 || lo !== 32'h77) begin errs++; $display("FAIL both_we got=%h/%h exp=77/77", hi, lo); end
        a = 32'd2; b = 32'd3; sgn = 1'b0; start = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h77 || lo !== 32'h77) begin errs++; $display("FAIL start_wins_hold got=%h/%h exp=77/77", hi, lo); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL start_wins_busy got=%b exp=1", busy); end
        for (j = 1; j < 40 && !done; j++) @(negedge clk);
        checks++; if (hi !== 32'h0 || lo !== 32'h6) begin errs++; $display("FAIL start_wins_result got=%h/%h exp=0/6", hi, lo); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_overlap;
        test_back_to_back;
        test_reset_mid;
        test_writes;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
